// File: rtl/score_display_ctrl.sv
// ---------------------------------------------------------------------------
// score_display_ctrl
//
// Game-phase sequencer for the Flappy Bird score display. Tracks the
// IDLE/PLAY/OVER phase, counts pipes cleared (saturating at MAX_SCORE),
// keeps the session high score and selects the value sent to the two-digit
// 7-segment decoder.
//
// Optional feature macro: SCORE_BLINK_EN
//   defined   : display blinks in OVER with half-period BLINK_CYCLES clocks
//   undefined : disp_blank tied to 0, no blink counter
//
// Parameters:
//   BLINK_CYCLES  clock cycles per blink half-period in OVER (>= 2)
//   MAX_SCORE     saturation value of score and high_score (<= 127)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   level; rising edge begins a game
//   pass        in   level; rising edge = one pipe cleared
//   crash       in   level; high = bird collided
//   show_high   in   select high score for display outside PLAY
//   disp_value  out  [6:0] value to score decoder (registered)
//   disp_blank  out  1 = decoder outputs forced blank
//   score       out  [6:0] current game score
//   high_score  out  [6:0] best score since reset
//   state       out  [1:0] 00 IDLE, 01 PLAY, 10 OVER
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | after reset, waiting for the first start edge
// PLAY  | game running, pass edges increment score
// OVER  | bird crashed, score frozen, waiting for start
// 11    | unreachable; recovers to IDLE on next edge
// ---------------------------------------------------------------------------
module score_display_ctrl #(
    parameter int BLINK_CYCLES = 25000000,
    parameter int MAX_SCORE    = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pass,
    input  logic       crash,
    input  logic       show_high,
    output logic [6:0] disp_value,
    output logic       disp_blank,
    output logic [6:0] score,
    output logic [6:0] high_score,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    localparam logic [6:0] MAX_S = 7'(MAX_SCORE);

    state_t st;
    logic   start_q;
    logic   pass_q;
    logic   start_rise;
    logic   pass_rise;

    // Previous-value registers reset high so a level held through reset
    // is not mistaken for a fresh edge.
    assign start_rise = start & ~start_q;
    assign pass_rise  = pass & ~pass_q;
    assign state      = st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= ST_IDLE;
            score      <= '0;
            high_score <= '0;
            disp_value <= '0;
            start_q    <= 1'b1;
            pass_q     <= 1'b1;
        end else begin
            start_q <= start;
            pass_q  <= pass;

            // Selection uses the pre-edge state/score, so the display trails
            // a score change by one clock.
            if (show_high && (st != ST_PLAY))
                disp_value <= high_score;
            else
                disp_value <= score;

            case (st)
                ST_IDLE: begin
                    if (start_rise) begin
                        st    <= ST_PLAY;
                        score <= '0;
                    end
                end
                ST_PLAY: begin
                    // crash has priority over a coincident pass edge
                    if (crash) begin
                        st <= ST_OVER;
                        if (score > high_score)
                            high_score <= score;
                    end else if (pass_rise && (score != MAX_S)) begin
                        score <= score + 7'd1;
                    end
                end
                ST_OVER: begin
                    if (start_rise) begin
                        st    <= ST_PLAY;
                        score <= '0;
                    end
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SCORE_BLINK_EN
    localparam int CW = $clog2(BLINK_CYCLES);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);

    logic [CW-1:0] blink_cnt;
    logic          stay_over;

    // Counter only runs on edges where the FSM is in OVER and remains there;
    // the entry edge and the leaving edge both clear it together with the
    // blank flag, so blanking starts BLINK_CYCLES clocks after entry.
    assign stay_over = (st == ST_OVER) && !start_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt  <= '0;
            disp_blank <= 1'b0;
        end else if (!stay_over) begin
            blink_cnt  <= '0;
            disp_blank <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt  <= '0;
            disp_blank <= ~disp_blank;
        end else begin
            blink_cnt  <= blink_cnt + CW'(1);
        end
    end
`else
    assign disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_score_display_ctrl.sv
module tb_score_display_ctrl;

    localparam int BC = 4;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PLAY = 2'b01;
    localparam logic [1:0] S_OVER = 2'b10;

`ifdef SCORE_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start, pass, crash, show_high;
    logic [6:0] disp_value, score, high_score;
    logic       disp_blank;
    logic [1:0] state;

    score_display_ctrl #(.BLINK_CYCLES(BC), .MAX_SCORE(99)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pass       (pass),
        .crash      (crash),
        .show_high  (show_high),
        .disp_value (disp_value),
        .disp_blank (disp_blank),
        .score      (score),
        .high_score (high_score),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic [6:0] sc;
        logic [6:0] hi;
        logic [6:0] dv;
        logic       bl;
        string      tag;
    } exp_t;

    typedef struct {
        logic       i_start, i_pass, i_crash, i_show;
        logic [1:0] st;
        logic [6:0] sc, hi, dv;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] sat(input int i);
        return (i > 99) ? 7'd99 : 7'(i);
    endfunction

    function automatic void add(input logic s, p, c, h, input logic [1:0] es,
                                input int esc, ehi, edv);
        vec_t v;
        v.i_start = s; v.i_pass = p; v.i_crash = c; v.i_show = h;
        v.st = es; v.sc = 7'(esc); v.hi = 7'(ehi); v.dv = 7'(edv);
        vecs.push_back(v);
    endfunction

    // Called at a negedge: drive inputs, queue expectation, sample #1 after
    // the next rising edge, then return at the following negedge.
    task automatic step(input string tag, input logic s, p, c, h,
                        input logic [1:0] es, input logic [6:0] esc, ehi, edv,
                        input logic ebl);
        exp_t e;
        start = s; pass = p; crash = c; show_high = h;
        e.st = es; e.sc = esc; e.hi = ehi; e.dv = edv; e.bl = ebl; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 8'd0, 8'd1);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_state"}, {6'd0, state}, {6'd0, e.st});
            chk({e.tag, "_score"}, {1'b0, score}, {1'b0, e.sc});
            chk({e.tag, "_high"},  {1'b0, high_score}, {1'b0, e.hi});
            chk({e.tag, "_disp"},  {1'b0, disp_value}, {1'b0, e.dv});
            chk({e.tag, "_blank"}, {7'd0, disp_blank}, {7'd0, e.bl});
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, {6'd0, state}, 8'd0);
        chk({tag, "_score"}, {1'b0, score}, 8'd0);
        chk({tag, "_high"},  {1'b0, high_score}, 8'd0);
        chk({tag, "_disp"},  {1'b0, disp_value}, 8'd0);
        chk({tag, "_blank"}, {7'd0, disp_blank}, 8'd0);
    endtask

    initial begin
        // Vector table: two games with show_high exercised, blank stays 0
        // because each OVER visit is shorter than one blink half-period.
        add(0,0,0,0, S_IDLE, 0,0,0);
        add(0,1,0,0, S_IDLE, 0,0,0);
        add(0,0,1,0, S_IDLE, 0,0,0);
        add(0,0,0,1, S_IDLE, 0,0,0);
        add(1,0,0,0, S_PLAY, 0,0,0);
        add(0,0,0,0, S_PLAY, 0,0,0);
        for (int i = 1; i <= 7; i++) begin
            add(0,1,0,0, S_PLAY, i,0,i-1);
            add(0,0,0,0, S_PLAY, i,0,i);
        end
        add(0,0,1,0, S_OVER, 7,7,7);
        add(0,0,0,0, S_OVER, 7,7,7);
        add(1,0,0,0, S_PLAY, 0,7,7);
        add(0,0,0,1, S_PLAY, 0,7,0);
        for (int i = 1; i <= 3; i++) begin
            add(0,1,0,0, S_PLAY, i,7,i-1);
            add(0,0,0,0, S_PLAY, i,7,i);
        end
        add(1,0,0,0, S_PLAY, 3,7,3);
        add(0,0,0,0, S_PLAY, 3,7,3);
        add(0,0,1,0, S_OVER, 3,7,3);
        add(0,0,0,1, S_OVER, 3,7,7);
        add(0,0,0,1, S_OVER, 3,7,7);
        add(0,0,0,0, S_OVER, 3,7,3);
        add(1,0,0,0, S_PLAY, 0,7,3);

        // Reset with start held high; no edge may be seen afterwards.
        reset = 1'b0; start = 1'b1; pass = 1'b0; crash = 1'b0; show_high = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("in_reset");
        reset = 1'b1;
        for (int i = 0; i < 5; i++)
            step("start_held", 1,0,0,0, S_IDLE, 7'd0, 7'd0, 7'd0, 1'b0);

        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].i_start, vecs[i].i_pass,
                 vecs[i].i_crash, vecs[i].i_show, vecs[i].st, vecs[i].sc,
                 vecs[i].hi, vecs[i].dv, 1'b0);

        // Saturation: 105 pulses, score must stop at 99.
        step("sat_pre", 0,0,0,0, S_PLAY, 7'd0, 7'd7, 7'd0, 1'b0);
        for (int i = 1; i <= 105; i++) begin
            step("sat_hi", 0,1,0,0, S_PLAY, sat(i), 7'd7, sat(i-1), 1'b0);
            step("sat_lo", 0,0,0,0, S_PLAY, sat(i), 7'd7, sat(i), 1'b0);
        end
        step("sat_crash", 0,0,1,0, S_OVER, 7'd99, 7'd99, 7'd99, 1'b0);
        step("sat_over",  0,0,0,0, S_OVER, 7'd99, 7'd99, 7'd99, 1'b0);
        // start and pass edges together in OVER: start wins, score 0
        step("start_pass", 1,1,0,0, S_PLAY, 7'd0, 7'd99, 7'd99, 1'b0);
        step("start_pass2", 0,0,0,0, S_PLAY, 7'd0, 7'd99, 7'd0, 1'b0);
        for (int i = 1; i <= 42; i++) begin
            step("to42_hi", 0,1,0,0, S_PLAY, 7'(i), 7'd99, 7'(i-1), 1'b0);
            step("to42_lo", 0,0,0,0, S_PLAY, 7'(i), 7'd99, 7'(i), 1'b0);
        end
        // crash and pass edge together: crash wins, score stays 42
        step("crash_pass", 0,1,1,0, S_OVER, 7'd42, 7'd99, 7'd42, 1'b0);

        // Blink over 12 further OVER cycles; show_high from k=6 shows 99.
        for (int k = 1; k <= 12; k++)
            step($sformatf("blink%0d", k), 0,0,0, logic'(k >= 6), S_OVER,
                 7'd42, 7'd99, (k >= 6) ? 7'd99 : 7'd42,
                 BLINK_ON ? logic'(((k / BC) % 2) == 1) : 1'b0);
        step("blink_exit", 1,0,0,0, S_PLAY, 7'd0, 7'd99, 7'd42, 1'b0);
        step("blink_exit2", 0,0,0,0, S_PLAY, 7'd0, 7'd99, 7'd0, 1'b0);

        // Asynchronous reset mid-game at score 12.
        for (int i = 1; i <= 12; i++) begin
            step("to12_hi", 0,1,0,0, S_PLAY, 7'(i), 7'd99, 7'(i-1), 1'b0);
            step("to12_lo", 0,0,0,0, S_PLAY, 7'(i), 7'd99, 7'(i), 1'b0);
        end
        reset = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        reset = 1'b1;
        step("post_rst", 0,0,0,0, S_IDLE, 7'd0, 7'd0, 7'd0, 1'b0);
        step("post_rst_start", 1,0,0,0, S_PLAY, 7'd0, 7'd0, 7'd0, 1'b0);
        step("post_rst_idle", 0,0,0,0, S_PLAY, 7'd0, 7'd0, 7'd0, 1'b0);

        chk("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
